pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Consumes the decoded control fields of the instruction in ID and tracks every in-flight instruction through EX, MEM and WB in an internal shadow pipeline.
- From that state it generates the PC/IF-ID stall, the IF/ID and ID/EX flushes, and the EX-stage operand forwarding selects for the 5-stage MIPS pipeline.
- It also keeps a saturating stall-cycle counter for performance analysis.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  rs field of ID instruction
id_rt  in  REG_AW  rt field of ID instruction
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_reg_write  in  1  decoded RegWrite
id_mem_read  in  1  decoded MemRead (load)
id_wr_addr  in  REG_AW  destination after RegDst selection (rt/rd/31)
id_pcsrc  in  2  decoded PCSrc (0 seq, 1 j/jal, 2 jr/jalr)
ex_branch_taken  in  1  branch in EX resolved taken this cycle
stall  out  1  hold PC and IF/ID
flush_if_id  out  1  replace IF/ID with nop at next edge
flush_id_ex  out  1  replace ID/EX with nop at next edge
fwd_a  out  2  EX operand A select: 0 regfile, 1 EX/MEM result, 2 MEM/WB result
fwd_b  out  2  EX operand B select, same encoding as fwd_a
stall_cycles  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Shadow slots EX, MEM, WB each hold {v, rw, mr, wa, rs, rt}. EX additionally holds the use_rs/use_rt bits.
- Every clock edge:
  - WB <= MEM, MEM <= EX.
  - If flush_id_ex = 1 or stall = 1, EX <= invalid (all zero).
  - Otherwise EX <= ID fields, with v = id_valid.
- A slot "writes r" iff v & rw & wa != 0 & wa == r. Register 0 never causes a hazard or a forward.
- Load-use hazard: ID reads r (use bit set, id_valid), and the EX slot writes r with mr = 1.
- Jump-register hazard: id_pcsrc = 2 & id_valid, and either:
  - the EX slot writes id_rs, or
  - the MEM slot writes id_rs with mr = 1.
- Stall and flush generation:
  - stall = (load-use | jr hazard) & ~ex_branch_taken.
  - flush_id_ex = ex_branch_taken | stall.
  - flush_if_id = ex_branch_taken | (id_valid & id_pcsrc != 0 & ~stall).
- Priority: a taken branch overrides any stall. The younger jump in ID is discarded by the flush, so no jump flush is attributed to it.
- Forwarding:
  - fwd_a = 1 if the MEM slot writes EX.rs and EX.use_rs; else 2 if the WB slot writes EX.rs and EX.use_rs; else 0.
  - fwd_b uses the same rule on EX.rt / EX.use_rt.
  - MEM has priority over WB.
- Timing: stall, flush_* and fwd_* are combinational from the current slots and current inputs, i.e. 0-cycle latency. Only the slots and the counter are registered.
- A load-use stall lasts exactly 1 cycle. A jr hazard lasts 1 or 2 cycles until the producer reaches a forwardable stage.
- stall_cycles increments on each cycle with stall = 1 and holds at all-ones.
- Reset:
  - While reset = 1, all slots are cleared, stall_cycles = 0, and every output is forced to 0.
  - Reset asserted mid-stall or mid-flush takes effect at the next edge. No pending hazard survives it.
- id_valid = 0: the instruction causes no hazard and no jump flush, and an invalid slot enters EX.

Test Plan:
- lw $8 (id_mem_read=1, wa=8), then next cycle add reading rs=8 → stall=1 and flush_id_ex=1 for exactly 1 cycle; two cycles later fwd_a=2; stall_cycles=1.
- add wa=9, then sub rs=9, rt=9 → no stall; next cycle fwd_a=1, fwd_b=1; one cycle later (if still in EX) MEM priority holds over the WB match.
- addi wa=31 followed by jr rs=31 → stall for 1 cycle, then flush_if_id=1 with stall=0. Also lw wa=31 then jr rs=31 → stall for 2 cycles.
- ex_branch_taken=1 in the same cycle as a load-use condition → stall=0, flush_if_id=1, flush_id_ex=1, stall_cycles unchanged.
- Instruction writing wa=0 followed by a reader of $0 → stall=0, fwd_a=fwd_b=0 throughout.
- Assert reset during a load-use stall → next cycle all outputs are 0 and stall_cycles=0. Run 2^CNT_W+5 stall cycles → stall_cycles saturates at all-ones.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Hazard controller for a 5-stage MIPS pipeline. It shadows the
//            in-flight instructions in EX/MEM/WB and produces the PC/IF-ID
//            stall, IF/ID and ID/EX flushes, EX forwarding selects and a
//            saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic [REG_AW-1:0] id_wr_addr,
   input  logic [1:0]        id_pcsrc,
   input  logic              ex_branch_taken,
   output logic              stall,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam logic [1:0] C_PCSRC_JR  = 2'd2;
   localparam logic [1:0] C_FWD_NONE  = 2'd0;
   localparam logic [1:0] C_FWD_EXMEM = 2'd1;
   localparam logic [1:0] C_FWD_MEMWB = 2'd2;

   // EX shadow slot: everything the hazard and forwarding logic can ask of it.
   logic              r_ex_v;
   logic              r_ex_rw;
   logic              r_ex_mr;
   logic [REG_AW-1:0] r_ex_wa;
   logic [REG_AW-1:0] r_ex_rs;
   logic [REG_AW-1:0] r_ex_rt;
   logic              r_ex_use_rs;
   logic              r_ex_use_rt;

   // Older slots only act as producers, so only their producer fields are
   // kept (source fields would never be read again once past EX).
   logic              r_mem_v;
   logic              r_mem_rw;
   logic              r_mem_mr;
   logic [REG_AW-1:0] r_mem_wa;
   logic              r_wb_v;
   logic              r_wb_rw;
   logic [REG_AW-1:0] r_wb_wa;

   logic [CNT_W-1:0]  r_cnt;

   logic              w_load_use;
   logic              w_jr_hazard;
   logic              w_stall;
   logic              w_flush_id_ex;
   logic              w_flush_if_id;
   logic [1:0]        w_fwd_a;
   logic [1:0]        w_fwd_b;

   // A slot "writes r" only for a real, register-writing instruction with a
   // non-zero destination equal to r; $0 never produces a hazard or forward.
   function automatic logic slot_writes(input logic v, input logic rw,
                                        input logic [REG_AW-1:0] wa,
                                        input logic [REG_AW-1:0] r);
      return v & rw & (wa != '0) & (wa == r);
   endfunction

   // Forward select for one EX operand; the younger MEM result wins over WB.
   function automatic logic [1:0] fwd_sel(input logic use_r,
                                          input logic [REG_AW-1:0] r,
                                          input logic mv, input logic mrw,
                                          input logic [REG_AW-1:0] mwa,
                                          input logic wv, input logic wrw,
                                          input logic [REG_AW-1:0] wwa);
      if (use_r && slot_writes(mv, mrw, mwa, r))
         return C_FWD_EXMEM;
      else if (use_r && slot_writes(wv, wrw, wwa, r))
         return C_FWD_MEMWB;
      else
         return C_FWD_NONE;
   endfunction

   // Hazard detection, stall/flush generation and forwarding selects.
   always_comb begin
      w_load_use    = 1'b0;
      w_jr_hazard   = 1'b0;
      w_stall       = 1'b0;
      w_flush_id_ex = 1'b0;
      w_flush_if_id = 1'b0;
      w_fwd_a       = C_FWD_NONE;
      w_fwd_b       = C_FWD_NONE;

      // A load in EX cannot supply its data to the ID instruction in time.
      w_load_use = id_valid & r_ex_mr &
                   ((id_use_rs & slot_writes(r_ex_v, r_ex_rw, r_ex_wa, id_rs)) |
                    (id_use_rt & slot_writes(r_ex_v, r_ex_rw, r_ex_wa, id_rt)));

      // jr/jalr reads rs in ID, so any EX producer, or a load still in MEM,
      // is too late for the jump target.
      w_jr_hazard = id_valid & (id_pcsrc == C_PCSRC_JR) &
                    (slot_writes(r_ex_v, r_ex_rw, r_ex_wa, id_rs) |
                     (r_mem_mr & slot_writes(r_mem_v, r_mem_rw, r_mem_wa, id_rs)));

      // A taken branch squashes the ID instruction, so its hazards are moot.
      w_stall       = (w_load_use | w_jr_hazard) & ~ex_branch_taken;
      w_flush_id_ex = ex_branch_taken | w_stall;
      w_flush_if_id = ex_branch_taken | (id_valid & (id_pcsrc != 2'b00) & ~w_stall);

      w_fwd_a = fwd_sel(r_ex_use_rs, r_ex_rs, r_mem_v, r_mem_rw, r_mem_wa,
                        r_wb_v, r_wb_rw, r_wb_wa);
      w_fwd_b = fwd_sel(r_ex_use_rt, r_ex_rt, r_mem_v, r_mem_rw, r_mem_wa,
                        r_wb_v, r_wb_rw, r_wb_wa);
   end

   // Shadow pipeline advance; a flushed or invalid ID inserts an all-zero slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_v      <= 1'b0;
         r_ex_rw     <= 1'b0;
         r_ex_mr     <= 1'b0;
         r_ex_wa     <= '0;
         r_ex_rs     <= '0;
         r_ex_rt     <= '0;
         r_ex_use_rs <= 1'b0;
         r_ex_use_rt <= 1'b0;
         r_mem_v     <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_mr    <= 1'b0;
         r_mem_wa    <= '0;
         r_wb_v      <= 1'b0;
         r_wb_rw     <= 1'b0;
         r_wb_wa     <= '0;
      end else begin
         r_wb_v   <= r_mem_v;
         r_wb_rw  <= r_mem_rw;
         r_wb_wa  <= r_mem_wa;
         r_mem_v  <= r_ex_v;
         r_mem_rw <= r_ex_rw;
         r_mem_mr <= r_ex_mr;
         r_mem_wa <= r_ex_wa;
         if (w_flush_id_ex || !id_valid) begin
            r_ex_v      <= 1'b0;
            r_ex_rw     <= 1'b0;
            r_ex_mr     <= 1'b0;
            r_ex_wa     <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
         end else begin
            r_ex_v      <= 1'b1;
            r_ex_rw     <= id_reg_write;
            r_ex_mr     <= id_mem_read;
            r_ex_wa     <= id_wr_addr;
            r_ex_rs     <= id_rs;
            r_ex_rt     <= id_rt;
            r_ex_use_rs <= id_use_rs;
            r_ex_use_rt <= id_use_rt;
         end
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (w_stall && (r_cnt != '1))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   // Reset forces every output low immediately, not only after the edge.
   assign stall        = w_stall & ~reset;
   assign flush_id_ex  = w_flush_id_ex & ~reset;
   assign flush_if_id  = w_flush_if_id & ~reset;
   assign fwd_a        = reset ? C_FWD_NONE : w_fwd_a;
   assign fwd_b        = reset ? C_FWD_NONE : w_fwd_b;
   assign stall_cycles = reset ? '0 : r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl: directed vector table,
//            reset/saturation sequences and random traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
   logic       ex_branch_taken;
   logic [4:0] id_rs, id_rt, id_wr_addr;
   logic [1:0] id_pcsrc;

   logic        stall, flush_if_id, flush_id_ex;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cycles;

   logic        stall_s, fii_s, fie_s;
   logic [1:0]  fa_s, fb_s;
   logic [3:0]  cnt_s;

   pipe_hazard_ctrl dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_wr_addr(id_wr_addr), .id_pcsrc(id_pcsrc),
      .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_if_id(flush_if_id),
      .flush_id_ex(flush_id_ex), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
   );

   // Narrow-counter copy so saturation is reachable in a short run.
   pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_s (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_wr_addr(id_wr_addr), .id_pcsrc(id_pcsrc),
      .ex_branch_taken(ex_branch_taken), .stall(stall_s), .flush_if_id(fii_s),
      .flush_id_ex(fie_s), .fwd_a(fa_s), .fwd_b(fb_s), .stall_cycles(cnt_s)
   );

   // Reference model: a list of in-flight instructions, index 0 = EX (youngest).
   typedef struct { bit v, rw, mr, urs, urt; int wa, rs, rt; } ins_t;
   ins_t pipe [3];
   int m_cnt, m_cnt_s;
   int e_stall, e_fii, e_fie, e_fa, e_fb, e_cnt, e_cnt_s;
   int checks = 0, errors = 0;

   typedef struct { int v, rw, mr, wa, rs, rt, urs, urt, pc, br, st, fii, fie, fa, fb, cn; } vec_t;
   vec_t tbl [27];

   function automatic vec_t V(input int v, rw, mr, wa, rs, rt, urs, urt, pc, br,
                              input int st, fii, fie, fa, fb, cn);
      vec_t t;
      t.v = v; t.rw = rw; t.mr = mr; t.wa = wa; t.rs = rs; t.rt = rt; t.urs = urs;
      t.urt = urt; t.pc = pc; t.br = br; t.st = st; t.fii = fii; t.fie = fie;
      t.fa = fa; t.fb = fb; t.cn = cn;
      return t;
   endfunction

   function automatic bit wr(input ins_t s, input int r);
      return s.v && s.rw && s.wa != 0 && s.wa == r;
   endfunction

   function automatic ins_t cur_id();
      ins_t d;
      d.v = id_valid; d.rw = id_reg_write; d.mr = id_mem_read; d.urs = id_use_rs;
      d.urt = id_use_rt; d.wa = int'(id_wr_addr); d.rs = int'(id_rs); d.rt = int'(id_rt);
      return d;
   endfunction

   function automatic int fsel(input bit u, input int r);
      if (u && wr(pipe[1], r)) return 1;
      if (u && wr(pipe[2], r)) return 2;
      return 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      ins_t d;
      bit lu, jr;
      d  = cur_id();
      lu = d.v && pipe[0].mr && ((d.urs && wr(pipe[0], d.rs)) || (d.urt && wr(pipe[0], d.rt)));
      jr = d.v && id_pcsrc == 2 && (wr(pipe[0], d.rs) || (pipe[1].mr && wr(pipe[1], d.rs)));
      e_stall = int'((lu || jr) && !ex_branch_taken);
      e_fie   = int'(ex_branch_taken || e_stall != 0);
      e_fii   = int'(ex_branch_taken || (d.v && id_pcsrc != 0 && e_stall == 0));
      e_fa    = fsel(pipe[0].urs, pipe[0].rs);
      e_fb    = fsel(pipe[0].urt, pipe[0].rt);
      e_cnt   = m_cnt;
      e_cnt_s = m_cnt_s;
      if (reset) begin
         e_stall = 0; e_fie = 0; e_fii = 0; e_fa = 0; e_fb = 0; e_cnt = 0; e_cnt_s = 0;
      end
   endtask

   task automatic model_advance();
      ins_t nop;
      nop = '{default: 0};
      if (reset) begin
         for (int k = 0; k < 3; k++) pipe[k] = nop;
         m_cnt = 0; m_cnt_s = 0;
      end else begin
         if (e_stall != 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
         end
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = (e_fie != 0 || !id_valid) ? nop : cur_id();
      end
   endtask

   // Compare both DUT copies with the model, then clock one cycle.
   task automatic step();
      model_eval();
      chk("stall", stall, e_stall);
      chk("flush_if_id", flush_if_id, e_fii);
      chk("flush_id_ex", flush_id_ex, e_fie);
      chk("fwd_a", fwd_a, e_fa);
      chk("fwd_b", fwd_b, e_fb);
      chk("stall_cycles", stall_cycles, e_cnt);
      chk("stall_cycles_narrow", cnt_s, e_cnt_s);
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic set_in(input int v, rw, mr, wa, rs, rt, urs, urt, pc, br);
      id_valid = v[0]; id_reg_write = rw[0]; id_mem_read = mr[0];
      id_wr_addr = wa[4:0]; id_rs = rs[4:0]; id_rt = rt[4:0];
      id_use_rs = urs[0]; id_use_rt = urt[0]; id_pcsrc = pc[1:0]; ex_branch_taken = br[0];
   endtask

   initial begin
      //              v rw mr wa rs rt urs urt pc br   st fii fie fa fb cnt
      tbl[0]  = V(1, 1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0); // lw $8
      tbl[1]  = V(1, 1, 0,10, 8, 9, 1, 1, 0, 0,  1, 0, 1, 0, 0, 0); // add uses $8
      tbl[2]  = V(1, 1, 0,10, 8, 9, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1); // replayed
      tbl[3]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 1); // WB forward
      tbl[4]  = V(1, 1, 0, 9, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1); // add wa=9
      tbl[5]  = V(1, 1, 0, 9, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1); // add wa=9
      tbl[6]  = V(1, 1, 0,11, 9, 9, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1); // sub $9,$9
      tbl[7]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1); // MEM beats WB
      tbl[8]  = V(1, 1, 0,31, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1); // addi $31
      tbl[9]  = V(1, 0, 0, 0,31, 0, 1, 0, 2, 0,  1, 0, 1, 0, 0, 1); // jr $31
      tbl[10] = V(1, 0, 0, 0,31, 0, 1, 0, 2, 0,  0, 1, 0, 0, 0, 2);
      tbl[11] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 2);
      tbl[12] = V(1, 1, 1,31, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2); // lw $31
      tbl[13] = V(1, 0, 0, 0,31, 0, 1, 0, 2, 0,  1, 0, 1, 0, 0, 2); // jr $31
      tbl[14] = V(1, 0, 0, 0,31, 0, 1, 0, 2, 0,  1, 0, 1, 0, 0, 3);
      tbl[15] = V(1, 0, 0, 0,31, 0, 1, 0, 2, 0,  0, 1, 0, 0, 0, 4);
      tbl[16] = V(1, 1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4); // lw $8
      tbl[17] = V(1, 1, 0,10, 8, 0, 1, 0, 0, 1,  0, 1, 1, 0, 0, 4); // use + taken br
      tbl[18] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4);
      tbl[19] = V(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4); // lw $0
      tbl[20] = V(1, 1, 0,12, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 4); // reads $0
      tbl[21] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4);
      tbl[22] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4);
      tbl[23] = V(1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 4); // j
      tbl[24] = V(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 4); // invalid j
      tbl[25] = V(0, 1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4); // invalid lw
      tbl[26] = V(1, 1, 0,10, 8, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 4); // no hazard

      for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
      m_cnt = 0; m_cnt_s = 0;

      // Reset
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      step();
      step();
      chk("reset_stall_cycles", stall_cycles, 0);
      reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < 27; i++) begin
         set_in(tbl[i].v, tbl[i].rw, tbl[i].mr, tbl[i].wa, tbl[i].rs, tbl[i].rt,
                tbl[i].urs, tbl[i].urt, tbl[i].pc, tbl[i].br);
         #2;
         chk($sformatf("tbl%0d_stall", i), stall, tbl[i].st);
         chk($sformatf("tbl%0d_flush_if_id", i), flush_if_id, tbl[i].fii);
         chk($sformatf("tbl%0d_flush_id_ex", i), flush_id_ex, tbl[i].fie);
         chk($sformatf("tbl%0d_fwd_a", i), fwd_a, tbl[i].fa);
         chk($sformatf("tbl%0d_fwd_b", i), fwd_b, tbl[i].fb);
         chk($sformatf("tbl%0d_stall_cycles", i), stall_cycles, tbl[i].cn);
         step();
      end

      // Reset asserted in the middle of a load-use stall
      set_in(1, 1, 1, 8, 0, 0, 0, 0, 0, 0);
      #2;
      step();
      set_in(1, 1, 0, 10, 8, 0, 1, 0, 0, 0);
      #2;
      chk("rst_pre_stall", stall, 1);
      reset = 1'b1;
      #1;
      chk("rst_during_stall", stall, 0);
      chk("rst_during_flush_id_ex", flush_id_ex, 0);
      chk("rst_during_cnt", stall_cycles, 0);
      step();
      reset = 1'b0;
      #2;
      chk("rst_after_stall", stall, 0);
      chk("rst_after_flush_id_ex", flush_id_ex, 0);
      chk("rst_after_cnt", stall_cycles, 0);
      step();

      // lw $31 / jr $31 pairs: two stall cycles each, until the narrow counter pins
      for (int i = 0; i < 11; i++) begin
         set_in(1, 1, 1, 31, 0, 0, 0, 0, 0, 0);
         #2; step();
         set_in(1, 0, 0, 0, 31, 0, 1, 0, 2, 0);
         #2; step();
         #2; step();
      end
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("sat_narrow_cnt", cnt_s, 15);
      chk("sat_wide_cnt", stall_cycles, 22);
      step();

      // Random traffic on a small register range to provoke collisions
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 63) == 0);
         set_in(int'($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                int'($urandom_range(0, 7) == 0));
         #2;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
